// File: rtl/uart_io_buffer.sv
// rtl/uart_io_buffer.sv - UART RX/TX byte ring FIFOs and CPU IN/OUT word transfer engine; optional UART_IO_ERR_STATUS_EN error status
module uart_io_buffer #(
    parameter int         RX_AW   = 11,
    parameter int         TX_AW   = 11,
    parameter logic [7:0] HS_BYTE = 8'hAA
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [2:0]       mode,
    input  logic [7:0]       rx_data,
    input  logic             rx_ready,
    input  logic             rx_ferr,
    output logic [7:0]       tx_data,
    output logic             tx_start,
    input  logic             tx_busy,
    input  logic             in_req,
    input  logic [1:0]       in_size,
    output logic [31:0]      in_data,
    output logic             in_ack,
    input  logic             out_req,
    input  logic [1:0]       out_size,
    input  logic [31:0]      out_data,
    output logic             out_ack,
    output logic             io_busy,
    output logic             hs_received,
    output logic             hs_sent,
    output logic [RX_AW:0]   rx_count,
    output logic [TX_AW:0]   tx_count
`ifdef UART_IO_ERR_STATUS_EN
    ,
    input  logic             err_clr,
    output logic             rx_ovf,
    output logic             rx_ferr_seen
`endif
);

    localparam int             RX_DEPTH    = 1 << RX_AW;
    localparam int             TX_DEPTH    = 1 << TX_AW;
    localparam logic [RX_AW:0] RX_FULL_CNT = (RX_AW+1)'(RX_DEPTH);
    localparam logic [TX_AW:0] TX_FULL_CNT = (TX_AW+1)'(TX_DEPTH);

    typedef enum logic [1:0] {T_IDLE, T_READ, T_START, T_HOLD} tx_state_t;
    typedef enum logic [1:0] {I_IDLE, I_WAIT, I_CAP} in_state_t;
    typedef enum logic {O_IDLE, O_PUSH} out_state_t;

    tx_state_t  t_state, t_next;
    in_state_t  i_state, i_next;
    out_state_t o_state, o_next;

    logic [7:0]       rx_mem [RX_DEPTH];
    logic [7:0]       tx_mem [TX_DEPTH];
    logic [RX_AW-1:0] rx_wp, rx_rp;
    logic [TX_AW-1:0] tx_wp, tx_rp;
    logic [7:0]       rx_q, tx_q, out_byte, tx_wdata;
    logic [TX_AW:0]   tx_free;
    logic [1:0]       in_n_m1, in_k, out_n_m1, out_k;
    logic [31:0]      in_buf, cap_word, out_buf;
    logic             rx_full, rx_push, rx_pop, tx_full, tx_push, tx_pop;
    logic             hs_pushed, hs_pend, hs_push;
    logic             in_accept, in_last, in_blocking;
    logic             out_accept, out_push, out_last, out_space_ok;

    assign rx_full      = (rx_count == RX_FULL_CNT);
    assign rx_push      = (mode == 3'd2) & rx_ready & ~rx_ferr & ~rx_full;
    assign rx_pop       = (i_state == I_WAIT) & (rx_count != '0);
    assign tx_full      = (tx_count == TX_FULL_CNT);
    assign tx_free      = TX_FULL_CNT - tx_count;
    // The handshake byte owns the TX write port in its cycle; OUT slips by one.
    assign hs_pend      = (mode == 3'd1) & ~hs_pushed;
    assign hs_push      = hs_pend & ~tx_full;
    // Reserve room for a pending handshake so an accepted OUT word always fits whole.
    assign out_space_ok = 32'(tx_free) >= (32'(out_size) + 32'(hs_pend) + 32'd1);
    // IN has priority: OUT waits until the IN side is idle and its ack has gone.
    assign in_blocking  = (in_req & ~in_ack) | in_ack | (i_state != I_IDLE);
    assign in_accept    = (i_state == I_IDLE) & in_req & ~in_ack;
    assign in_last      = (in_k == in_n_m1);
    assign out_accept   = (o_state == O_IDLE) & out_req & ~out_ack & ~in_blocking & out_space_ok;
    assign out_push     = (o_state == O_PUSH) & ~hs_push & ~tx_full;
    assign out_last     = (out_k == out_n_m1);
    assign out_byte     = 8'(out_buf >> {out_k, 3'b000});
    assign tx_push      = hs_push | out_push;
    assign tx_wdata     = hs_push ? HS_BYTE : out_byte;
    assign cap_word     = in_buf | ({24'd0, rx_q} << {in_k, 3'b000});
    assign tx_start     = (t_state == T_START);
    assign io_busy      = (in_req & ~in_ack) | (out_req & ~out_ack);
    assign hs_received  = rx_ready & ~rx_ferr & (rx_data == HS_BYTE);

    // FIFO storage writes; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp] <= rx_data;
        if (tx_push) tx_mem[tx_wp] <= tx_wdata;
    end

    // RX FIFO pointers, occupancy and registered read data.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_wp <= '0; rx_rp <= '0; rx_count <= '0; rx_q <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + RX_AW'(1);
            if (rx_pop) begin
                rx_q  <= rx_mem[rx_rp];
                rx_rp <= rx_rp + RX_AW'(1);
            end
            if (rx_push && !rx_pop)      rx_count <= rx_count + (RX_AW+1)'(1);
            else if (!rx_push && rx_pop) rx_count <= rx_count - (RX_AW+1)'(1);
        end
    end

    // TX FIFO pointers, occupancy and registered read data.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tx_wp <= '0; tx_rp <= '0; tx_count <= '0; tx_q <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + TX_AW'(1);
            if (tx_pop) begin
                tx_q  <= tx_mem[tx_rp];
                tx_rp <= tx_rp + TX_AW'(1);
            end
            if (tx_push && !tx_pop)      tx_count <= tx_count + (TX_AW+1)'(1);
            else if (!tx_push && tx_pop) tx_count <= tx_count - (TX_AW+1)'(1);
        end
    end

    // State registers for the TX drain, IN and OUT engines.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            t_state <= T_IDLE; i_state <= I_IDLE; o_state <= O_IDLE;
        end else begin
            t_state <= t_next; i_state <= i_next; o_state <= o_next;
        end
    end

    // TX drain next state: pop, load tx_data, pulse start, one cycle ignoring busy.
    always_comb begin
        t_next = t_state;
        tx_pop = 1'b0;
        case (t_state)
            T_IDLE:  if (tx_count != '0 && !tx_busy) begin
                         tx_pop = 1'b1;
                         t_next = T_READ;
                     end
            T_READ:  t_next = T_START;
            T_START: t_next = T_HOLD;
            default: t_next = T_IDLE;
        endcase
    end

    // IN and OUT next state.
    always_comb begin
        i_next = i_state;
        o_next = o_state;
        case (i_state)
            I_IDLE:  if (in_accept) i_next = I_WAIT;
            I_WAIT:  if (rx_count != '0) i_next = I_CAP;
            default: i_next = in_last ? I_IDLE : I_WAIT;
        endcase
        if (o_state == O_IDLE) begin
            if (out_accept) o_next = O_PUSH;
        end else if (out_push && out_last) begin
            o_next = O_IDLE;
        end
    end

    // Datapath: tx_data load, word assembly/disassembly, acks, handshake tracking.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tx_data <= '0; in_data <= '0; in_ack <= 1'b0; out_ack <= 1'b0;
            in_buf <= '0; in_n_m1 <= '0; in_k <= '0;
            out_buf <= '0; out_n_m1 <= '0; out_k <= '0;
            hs_pushed <= 1'b0; hs_sent <= 1'b0;
        end else begin
            in_ack  <= 1'b0;
            out_ack <= 1'b0;
            if (t_state == T_READ) tx_data <= tx_q;
            if (in_accept) begin
                in_n_m1 <= in_size; in_k <= '0; in_buf <= '0;
            end
            if (i_state == I_CAP) begin
                if (in_last) begin
                    in_data <= cap_word;
                    in_ack  <= 1'b1;
                end else begin
                    in_buf <= cap_word;
                    in_k   <= in_k + 2'd1;
                end
            end
            if (out_accept) begin
                out_buf <= out_data; out_n_m1 <= out_size; out_k <= '0;
            end
            if (out_push) begin
                out_k <= out_k + 2'd1;
                if (out_last) out_ack <= 1'b1;
            end
            if (hs_push) hs_pushed <= 1'b1;
            if (hs_pushed && tx_count == '0 && t_state == T_IDLE && !tx_busy) hs_sent <= 1'b1;
        end
    end

`ifdef UART_IO_ERR_STATUS_EN
    // Sticky error flags; a set in the same cycle as err_clr wins.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_ovf <= 1'b0; rx_ferr_seen <= 1'b0;
        end else begin
            if ((mode == 3'd2) && rx_ready && !rx_ferr && rx_full) rx_ovf <= 1'b1;
            else if (err_clr)                                      rx_ovf <= 1'b0;
            if (rx_ready && rx_ferr) rx_ferr_seen <= 1'b1;
            else if (err_clr)        rx_ferr_seen <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_uart_io_buffer.sv
// tb/tb_uart_io_buffer.sv - directed self-checking bench for uart_io_buffer (RX_AW=TX_AW=2)
module tb_uart_io_buffer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [2:0]  mode = '0;
    logic [7:0]  rx_data = '0;
    logic        rx_ready = 1'b0;
    logic        rx_ferr = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        in_req = 1'b0;
    logic [1:0]  in_size = '0;
    logic [31:0] in_data;
    logic        in_ack;
    logic        out_req = 1'b0;
    logic [1:0]  out_size = '0;
    logic [31:0] out_data = '0;
    logic        out_ack;
    logic        io_busy;
    logic        hs_received;
    logic        hs_sent;
    logic [2:0]  rx_count;
    logic [2:0]  tx_count;
`ifdef UART_IO_ERR_STATUS_EN
    logic        err_clr = 1'b0;
    logic        rx_ovf;
    logic        rx_ferr_seen;
`endif

    int vecs = 0;
    int errs = 0;

    logic [7:0] txq[$];
    int         tx_rd = 0;
    int         busy_cnt = 0;
    logic       force_busy = 1'b0;

    uart_io_buffer #(.RX_AW(2), .TX_AW(2), .HS_BYTE(8'hAA)) dut (
        .clk(clk), .rstn(rstn), .mode(mode),
        .rx_data(rx_data), .rx_ready(rx_ready), .rx_ferr(rx_ferr),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .in_req(in_req), .in_size(in_size), .in_data(in_data), .in_ack(in_ack),
        .out_req(out_req), .out_size(out_size), .out_data(out_data), .out_ack(out_ack),
        .io_busy(io_busy), .hs_received(hs_received), .hs_sent(hs_sent),
        .rx_count(rx_count), .tx_count(tx_count)
`ifdef UART_IO_ERR_STATUS_EN
        , .err_clr(err_clr), .rx_ovf(rx_ovf), .rx_ferr_seen(rx_ferr_seen)
`endif
    );

    always #5 clk = ~clk;

    // uart_tx stand-in: log launched bytes, stay busy for 4 cycles per frame
    assign tx_busy = force_busy | (busy_cnt != 0);
    always @(negedge clk) begin
        if (tx_start) begin
            txq.push_back(tx_data);
            busy_cnt = 4;
        end else if (busy_cnt > 0) begin
            busy_cnt = busy_cnt - 1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic fe);
        rx_data = b; rx_ferr = fe; rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0; rx_ferr = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (3) tick();
        vecs++; if (tx_start !== 1'b0) begin errs++; $display("FAIL rst_tx_start: got %b want 0", tx_start); end
        vecs++; if (tx_data !== 8'h00) begin errs++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
        vecs++; if (in_data !== 32'h0) begin errs++; $display("FAIL rst_in_data: got %h want 0", in_data); end
        vecs++; if ({in_ack, out_ack, io_busy} !== 3'b000) begin errs++; $display("FAIL rst_acks: got %b want 000", {in_ack, out_ack, io_busy}); end
        vecs++; if ({hs_sent, hs_received} !== 2'b00) begin errs++; $display("FAIL rst_hs: got %b want 00", {hs_sent, hs_received}); end
        vecs++; if ({rx_count, tx_count} !== 6'd0) begin errs++; $display("FAIL rst_counts: got rx=%0d tx=%0d want 0 0", rx_count, tx_count); end
`ifdef UART_IO_ERR_STATUS_EN
        vecs++; if ({rx_ovf, rx_ferr_seen} !== 2'b00) begin errs++; $display("FAIL rst_err: got %b want 00", {rx_ovf, rx_ferr_seen}); end
`endif
        rstn = 1'b1;
        repeat (2) tick();
        vecs++; if (tx_count !== 3'd0) begin errs++; $display("FAIL idle_tx_count: got %0d want 0", tx_count); end
    endtask

    task automatic test_handshake;
        logic busy_at_set;
        busy_at_set = 1'b1;
        mode = 3'd1;
        for (int n = 0; n < 60; n++) begin
            tick();
            if (hs_sent) begin busy_at_set = tx_busy; break; end
        end
        vecs++; if (hs_sent !== 1'b1) begin errs++; $display("FAIL hs_sent: got %b want 1", hs_sent); end
        vecs++; if (busy_at_set !== 1'b0) begin errs++; $display("FAIL hs_sent_busy: tx_busy %b when hs_sent rose, want 0", busy_at_set); end
        vecs++; if (txq.size() != 1) begin errs++; $display("FAIL hs_frames: got %0d want 1", txq.size()); end
        if (txq.size() >= 1) begin
            vecs++; if (txq[0] !== 8'hAA) begin errs++; $display("FAIL hs_byte: got %h want aa", txq[0]); end
        end
        repeat (20) tick();
        vecs++; if (txq.size() != 1) begin errs++; $display("FAIL hs_once: got %0d frames want 1", txq.size()); end
        tx_rd = txq.size();
    endtask

    task automatic test_rx_in;
        logic [31:0] got;
        int          acks;
        got = '0; acks = 0;
        mode = 3'd2;
        send_rx(8'h11, 1'b0); send_rx(8'h22, 1'b0); send_rx(8'h33, 1'b0); send_rx(8'h44, 1'b0);
        vecs++; if (rx_count !== 3'd4) begin errs++; $display("FAIL rx_fill: got %0d want 4", rx_count); end
        in_size = 2'd3; in_req = 1'b1;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (in_ack) begin acks++; got = in_data; break; end
        end
        in_req = 1'b0;
        repeat (5) begin tick(); if (in_ack) acks++; end
        vecs++; if (got !== 32'h44332211) begin errs++; $display("FAIL in_word4: got %h want 44332211", got); end
        vecs++; if (acks != 1) begin errs++; $display("FAIL in_ack_once: got %0d want 1", acks); end
        vecs++; if (rx_count !== 3'd0) begin errs++; $display("FAIL rx_drained: got %0d want 0", rx_count); end
    endtask

    task automatic test_in_stall;
        int   early;
        logic seen, busy_at_ack;
        early = 0; seen = 1'b0; busy_at_ack = 1'b1;
        in_size = 2'd0; in_req = 1'b1;
        repeat (10) begin tick(); if (in_ack) early++; end
        vecs++; if (io_busy !== 1'b1) begin errs++; $display("FAIL stall_busy: got %b want 1", io_busy); end
        vecs++; if (early != 0) begin errs++; $display("FAIL stall_noack: got %0d acks want 0", early); end
        vecs++; if (in_data !== 32'h44332211) begin errs++; $display("FAIL in_data_held: got %h want 44332211", in_data); end
        rx_data = 8'h5A; rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (in_ack) begin seen = 1'b1; busy_at_ack = io_busy; break; end
        end
        vecs++; if (!seen || in_data !== 32'h0000005A) begin errs++; $display("FAIL in_late_byte: got %h ack=%b want 0000005a", in_data, seen); end
        vecs++; if (busy_at_ack !== 1'b0) begin errs++; $display("FAIL stall_release: io_busy %b at ack want 0", busy_at_ack); end
        in_req = 1'b0;
        tick();
    endtask

    task automatic test_hs_detect;
        mode = 3'd0;
        rx_data = 8'hAA; rx_ferr = 1'b0; rx_ready = 1'b1; #1;
        vecs++; if (hs_received !== 1'b1) begin errs++; $display("FAIL hs_rx_hit: got %b want 1", hs_received); end
        rx_ferr = 1'b1; #1;
        vecs++; if (hs_received !== 1'b0) begin errs++; $display("FAIL hs_rx_ferr: got %b want 0", hs_received); end
        rx_ferr = 1'b0; rx_data = 8'h55; #1;
        vecs++; if (hs_received !== 1'b0) begin errs++; $display("FAIL hs_rx_other: got %b want 0", hs_received); end
        rx_data = 8'hAA;
        tick();
        rx_ready = 1'b0;
        tick();
        vecs++; if (rx_count !== 3'd0) begin errs++; $display("FAIL rx_mode_gate: got %0d want 0", rx_count); end
    endtask

    task automatic test_ferr_drop;
        mode = 3'd2;
        send_rx(8'h77, 1'b1);
        vecs++; if (rx_count !== 3'd0) begin errs++; $display("FAIL ferr_drop: got %0d want 0", rx_count); end
`ifdef UART_IO_ERR_STATUS_EN
        vecs++; if (rx_ferr_seen !== 1'b1) begin errs++; $display("FAIL ferr_seen: got %b want 1", rx_ferr_seen); end
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        vecs++; if (rx_ferr_seen !== 1'b0) begin errs++; $display("FAIL ferr_clr: got %b want 0", rx_ferr_seen); end
`endif
    endtask

    task automatic test_rx_overflow;
        logic [31:0] got;
        got = '0;
        mode = 3'd2;
        for (int i = 1; i <= 5; i++) send_rx(8'(i), 1'b0);
        vecs++; if (rx_count !== 3'd4) begin errs++; $display("FAIL rx_full_count: got %0d want 4", rx_count); end
`ifdef UART_IO_ERR_STATUS_EN
        vecs++; if (rx_ovf !== 1'b1) begin errs++; $display("FAIL rx_ovf: got %b want 1", rx_ovf); end
`endif
        in_size = 2'd3; in_req = 1'b1;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (in_ack) begin got = in_data; break; end
        end
        in_req = 1'b0;
        tick();
        vecs++; if (got !== 32'h04030201) begin errs++; $display("FAIL rx_wrap_word: got %h want 04030201", got); end
        vecs++; if (rx_count !== 3'd0) begin errs++; $display("FAIL rx_ovf_drain: got %0d want 0", rx_count); end
    endtask

    task automatic test_out;
        int lat;
        lat = 0;
        out_size = 2'd1; out_data = 32'h0000BEEF; out_req = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (out_ack) begin lat = n; break; end
        end
        out_req = 1'b0;
        vecs++; if (lat != 3) begin errs++; $display("FAIL out_latency: got %0d want 3", lat); end
        for (int n = 0; n < 80 && txq.size() < tx_rd + 2; n++) tick();
        vecs++; if (txq.size() != tx_rd + 2) begin errs++; $display("FAIL out_frames: got %0d want %0d", txq.size(), tx_rd + 2); end
        if (txq.size() >= tx_rd + 2) begin
            vecs++; if ({txq[tx_rd], txq[tx_rd+1]} !== 16'hEFBE) begin errs++; $display("FAIL out_order: got %h%h want efbe", txq[tx_rd], txq[tx_rd+1]); end
        end
        tx_rd = txq.size();
    endtask

    task automatic test_back_to_back;
        int ci, co;
        logic [31:0] got;
        ci = 0; co = 0; got = '0;
        send_rx(8'h99, 1'b0);
        in_size = 2'd0; out_size = 2'd0; out_data = 32'h00000066;
        in_req = 1'b1; out_req = 1'b1;
        for (int c = 1; c <= 30 && co == 0; c++) begin
            tick();
            if (in_ack) begin ci = c; got = in_data; in_req = 1'b0; end
            if (out_ack) begin co = c; out_req = 1'b0; end
        end
        in_req = 1'b0; out_req = 1'b0;
        vecs++; if (ci != 3) begin errs++; $display("FAIL b2b_in_first: in_ack at %0d want 3", ci); end
        vecs++; if (co != ci + 3) begin errs++; $display("FAIL b2b_out_after: out_ack at %0d want %0d", co, ci + 3); end
        vecs++; if (got !== 32'h00000099) begin errs++; $display("FAIL b2b_in_data: got %h want 00000099", got); end
        for (int n = 0; n < 60 && txq.size() <= tx_rd; n++) tick();
        vecs++; if (txq.size() <= tx_rd || txq[tx_rd] !== 8'h66) begin errs++; $display("FAIL b2b_tx_byte: frames %0d want byte 66", txq.size() - tx_rd); end
        tx_rd = txq.size();
    endtask

    task automatic test_tx_full;
        logic [7:0] exp [5];
        int early, acked, late, base;
        exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        early = 0; acked = 0; late = 0;
        for (int n = 0; n < 60 && (tx_count != 0 || tx_busy); n++) tick();
        force_busy = 1'b1;
        tick();
        out_size = 2'd3; out_data = 32'h44332211; out_req = 1'b1;
        for (int n = 0; n < 20; n++) begin tick(); if (out_ack) break; end
        out_req = 1'b0;
        tick();
        vecs++; if (tx_count !== 3'd4) begin errs++; $display("FAIL tx_full_count: got %0d want 4", tx_count); end
        out_size = 2'd0; out_data = 32'h00000055; out_req = 1'b1;
        repeat (8) begin tick(); if (out_ack) early++; end
        vecs++; if (early != 0 || io_busy !== 1'b1) begin errs++; $display("FAIL tx_full_stall: acks %0d io_busy %b want 0 1", early, io_busy); end
        force_busy = 1'b0;
        for (int n = 0; n < 30; n++) begin tick(); if (out_ack) begin acked = 1; break; end end
        out_req = 1'b0;
        vecs++; if (acked != 1) begin errs++; $display("FAIL tx_full_ack: got %0d want 1", acked); end
        for (int n = 0; n < 200 && txq.size() < tx_rd + 5; n++) tick();
        vecs++; if (txq.size() != tx_rd + 5) begin errs++; $display("FAIL tx_full_frames: got %0d want %0d", txq.size() - tx_rd, 5); end
        for (int i = 0; i < 5; i++) begin
            if (txq.size() > tx_rd + i) begin
                vecs++; if (txq[tx_rd+i] !== exp[i]) begin errs++; $display("FAIL tx_full_byte%0d: got %h want %h", i, txq[tx_rd+i], exp[i]); end
            end
        end
        tx_rd = txq.size();

        for (int n = 0; n < 60 && (tx_count != 0 || tx_busy); n++) tick();
        force_busy = 1'b1;
        tick();
        out_size = 2'd3; out_data = 32'hDDCCBB01; out_req = 1'b1;
        for (int n = 0; n < 20; n++) begin tick(); if (out_ack) break; end
        out_req = 1'b0;
        tick();
        out_size = 2'd0; out_data = 32'h000000EE; out_req = 1'b1;
        repeat (4) begin tick(); if (out_ack) late++; end
        base = txq.size();
        rstn = 1'b0;
        repeat (2) begin tick(); if (out_ack) late++; end
        out_req = 1'b0; force_busy = 1'b0;
        rstn = 1'b1;
        repeat (10) begin tick(); if (out_ack) late++; end
        vecs++; if (late != 0) begin errs++; $display("FAIL rst_mid_ack: got %0d acks want 0", late); end
        vecs++; if ({rx_count, tx_count} !== 6'd0) begin errs++; $display("FAIL rst_mid_counts: got rx=%0d tx=%0d want 0 0", rx_count, tx_count); end
        vecs++; if (txq.size() != base) begin errs++; $display("FAIL rst_mid_tx: got %0d new frames want 0", txq.size() - base); end
        vecs++; if (hs_sent !== 1'b0) begin errs++; $display("FAIL rst_mid_hs: got %b want 0", hs_sent); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_handshake();
        test_rx_in();
        test_in_stall();
        test_hs_detect();
        test_ferr_drop();
        test_rx_overflow();
        test_out();
        test_back_to_back();
        test_tx_full();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
